// File: rtl/ariane_pkg.sv
// TLB refill bundle and page-table level encoding.
package ariane_pkg;

    typedef logic [1:0] lvl_t;

    localparam lvl_t LVL_4K = 2'd0;
    localparam lvl_t LVL_2M = 2'd1;
    localparam lvl_t LVL_1G = 2'd2;

    localparam int ASID_MAX = 16;

    typedef struct packed {
        logic                valid;
        logic                is_2M;
        logic                is_1G;
        logic                napot_bits;
        logic [26:0]         vpn;
        logic [ASID_MAX-1:0] asid;
        riscv::pte_t         content;
    } tlb_update_t;

endpackage

// File: rtl/riscv.sv
// Sv39 PTE layout and architectural widths.
package riscv;

    localparam int VLEN = 64;
    localparam int PLEN = 56;

    typedef struct packed {
        logic        n;
        logic [8:0]  reserved;
        logic [43:0] ppn;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } pte_t;

endpackage

// File: rtl/sv39_ptw_napot_pkg.sv
// Walker FSM states and VPN slicing helper.
package sv39_ptw_napot_pkg;

    import ariane_pkg::*;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        ERR,
        DRAIN
    } ptw_state_e;

    function automatic logic [8:0] vpn_at(
        input logic [63:0] va,
        input lvl_t        lvl
    );
        logic [8:0] vpn;
        vpn = va[20:12];
        unique case (1'b1)
            lvl == LVL_1G: vpn = va[38:30];
            lvl == LVL_2M: vpn = va[29:21];
            default: ;
        endcase
        return vpn;
    endfunction

endpackage

// File: rtl/ptw_pte_check.sv
// Combinational PTE legality check; N-bit handling gated
// by PTW_SVNAPOT_EN (otherwise bit 63 is reserved).
module ptw_pte_check
    import riscv::*;
    import ariane_pkg::*;
(
    input  pte_t pte_i,
    input  lvl_t lvl_i,
    output logic invalid_o,
    output logic leaf_o,
    output logic misaligned_o,
    output logic napot_o
);

    logic unused_ok;
    assign unused_ok = ^{pte_i.rsw, pte_i.d, pte_i.a,
                         pte_i.g, pte_i.u, pte_i.ppn[43:18]};

    always_comb begin
        leaf_o       = pte_i.r | pte_i.x;
        invalid_o    = !pte_i.v
                     || (!pte_i.r && pte_i.w)
                     || (|pte_i.reserved);
        misaligned_o = 1'b0;
        unique case (1'b1)
            lvl_i == LVL_1G: misaligned_o = leaf_o && |pte_i.ppn[17:0];
            lvl_i == LVL_2M: misaligned_o = leaf_o && |pte_i.ppn[8:0];
            default: ;
        endcase
`ifdef PTW_SVNAPOT_EN
        // only a 64 KiB leaf at the 4K level may carry N
        napot_o   = pte_i.n && leaf_o && (lvl_i == LVL_4K)
                  && (pte_i.ppn[3:0] == 4'b1000);
        invalid_o = invalid_o || (pte_i.n && !napot_o);
`else
        napot_o   = 1'b0;
        invalid_o = invalid_o || pte_i.n;
`endif
    end

endmodule

// File: rtl/sv39_ptw_napot.sv
// Sv39 page-table walker with Svnapot refills.
// Svnapot decoding is enabled by defining PTW_SVNAPOT_EN.
module sv39_ptw_napot
    import riscv::*;
    import ariane_pkg::*;
    import sv39_ptw_napot_pkg::*;
#(
    parameter int ASID_WIDTH = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic [43:0]           satp_ppn_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [VLEN-1:0]       req_vaddr_i,
    input  logic [ASID_WIDTH-1:0] req_asid_i,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [PLEN-1:0]       mem_addr_o,
    input  logic                  mem_rvalid_i,
    input  logic [63:0]           mem_rdata_i,
    output tlb_update_t           update_o,
    output logic                  walk_done_o,
    output logic                  page_fault_o,
    output logic [VLEN-1:0]       fault_vaddr_o
);

    ptw_state_e            state_q, state_d;
    lvl_t                  lvl_q, lvl_d;
    logic [43:0]           ptr_q, ptr_d;
    logic [VLEN-1:0]       vaddr_q, vaddr_d;
    logic [ASID_WIDTH-1:0] asid_q, asid_d;
    pte_t                  pte_q, pte_d;
    logic                  napot_q, napot_d;
    logic                  flush_q, flush_d;
    logic [VLEN-1:0]       fva_q, fva_d;

    pte_t rd_pte;
    logic invalid, leaf, misaligned, napot;

    assign rd_pte        = pte_t'(mem_rdata_i);
    assign fault_vaddr_o = fva_q;

    ptw_pte_check i_check (
        .pte_i        (rd_pte),
        .lvl_i        (lvl_q),
        .invalid_o    (invalid),
        .leaf_o       (leaf),
        .misaligned_o (misaligned),
        .napot_o      (napot)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            lvl_q   <= LVL_1G;
            ptr_q   <= '0;
            vaddr_q <= '0;
            asid_q  <= '0;
            pte_q   <= '0;
            napot_q <= 1'b0;
            flush_q <= 1'b0;
            fva_q   <= '0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            ptr_q   <= ptr_d;
            vaddr_q <= vaddr_d;
            asid_q  <= asid_d;
            pte_q   <= pte_d;
            napot_q <= napot_d;
            flush_q <= flush_d;
            fva_q   <= fva_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lvl_d        = lvl_q;
        ptr_d        = ptr_q;
        vaddr_d      = vaddr_q;
        asid_d       = asid_q;
        pte_d        = pte_q;
        napot_d      = napot_q;
        flush_d      = flush_q;
        fva_d        = fva_q;
        req_ready_o  = 1'b0;
        mem_req_o    = 1'b0;
        mem_addr_o   = '0;
        update_o     = '0;
        walk_done_o  = 1'b0;
        page_fault_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready_o = !flush_i;
                if (req_valid_i && !flush_i) begin
                    vaddr_d = req_vaddr_i;
                    asid_d  = req_asid_i;
                    lvl_d   = LVL_1G;
                    ptr_d   = satp_ppn_i;
                    flush_d = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {ptr_q, vpn_at(vaddr_q, lvl_q), 3'b000};
                // a flush seen before the grant still aborts the walk
                if (flush_i) flush_d = 1'b1;
                if (mem_gnt_i)
                    state_d = (flush_i || flush_q) ? DRAIN : WAIT;
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    if (flush_i) begin
                        state_d = IDLE;
                    end else if (invalid) begin
                        state_d = ERR;
                    end else if (!leaf) begin
                        if (lvl_q == LVL_4K) begin
                            state_d = ERR;
                        end else begin
                            ptr_d   = rd_pte.ppn;
                            lvl_d   = lvl_t'(lvl_q - 2'd1);
                            state_d = REQ;
                        end
                    end else if (!rd_pte.a || misaligned) begin
                        state_d = ERR;
                    end else begin
                        pte_d   = rd_pte;
                        napot_d = napot;
                        if (napot) pte_d.ppn[3:0] = vaddr_q[15:12];
                        state_d = DONE;
                    end
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                update_o.valid      = 1'b1;
                update_o.is_1G      = (lvl_q == LVL_1G);
                update_o.is_2M      = (lvl_q == LVL_2M);
                update_o.napot_bits = napot_q;
                update_o.vpn        = vaddr_q[38:12];
                update_o.asid       = ASID_MAX'(asid_q);
                update_o.content    = pte_q;
                walk_done_o         = 1'b1;
                state_d             = IDLE;
            end
            ERR: begin
                page_fault_o = 1'b1;
                walk_done_o  = 1'b1;
                state_d      = IDLE;
            end
            DRAIN: begin
                if (mem_rvalid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == ERR && state_q != ERR) fva_d = vaddr_q;
    end

endmodule

// File: tb/tb_sv39_ptw_napot.sv
// Directed checks for sv39_ptw_napot.
// Svnapot expectations follow PTW_SVNAPOT_EN.
module tb_sv39_ptw_napot;
    import riscv::*;
    import ariane_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        flush_i = 1'b0;
    logic [43:0] satp = 44'h80000;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_vaddr = '0;
    logic [0:0]  req_asid = '0;
    logic        mem_req;
    logic        mem_gnt;
    logic        gnt_en = 1'b1;
    logic [55:0] mem_addr;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = '0;
    tlb_update_t upd;
    logic        walk_done;
    logic        page_fault;
    logic [63:0] fault_vaddr;

    logic [63:0] pmem [logic [55:0]];
    int n_chk  = 0;
    int n_pass = 0;
    int gnt_stall = 0;
    int rv_delay  = 0;

    localparam logic [55:0] A_L2   = 56'h8000_0008;
    localparam logic [55:0] A_L1   = 56'h8000_1010;
    localparam logic [55:0] A_L0   = 56'h8000_2018;
    localparam logic [55:0] A_L0NP = 56'h8000_2028;
    localparam logic [63:0] VA4K   = 64'h4040_3000;
    localparam logic [63:0] VANP   = 64'h4040_5000;

    always #5 clk = ~clk;
    assign mem_gnt = mem_req && gnt_en;

    sv39_ptw_napot dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .satp_ppn_i    (satp),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_vaddr_i   (req_vaddr),
        .req_asid_i    (req_asid),
        .mem_req_o     (mem_req),
        .mem_gnt_i     (mem_gnt),
        .mem_addr_o    (mem_addr),
        .mem_rvalid_i  (mem_rvalid),
        .mem_rdata_i   (mem_rdata),
        .update_o      (upd),
        .walk_done_o   (walk_done),
        .page_fault_o  (page_fault),
        .fault_vaddr_o (fault_vaddr)
    );

    function automatic logic [63:0] mk(
        input logic [43:0] ppn,
        input logic [9:0]  flags
    );
        return {10'b0, ppn, flags};
    endfunction

    task automatic chk(
        input string       tag,
        input logic [63:0] got,
        input logic [63:0] exp
    );
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // memory model: grant unless stalled, data rv_delay cycles late
    initial begin : resp
        logic        pend;
        logic [55:0] paddr;
        int          cnt;
        pend  = 1'b0;
        paddr = '0;
        cnt   = 0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = pmem.exists(paddr) ? pmem[paddr] : 64'h0;
                    pend       = 1'b0;
                end else begin
                    cnt--;
                end
            end
            gnt_en = 1'b1;
            if (mem_req && gnt_stall > 0) begin
                gnt_en = 1'b0;
                gnt_stall--;
            end
            if (mem_req && gnt_en) begin
                pend  = 1'b1;
                paddr = mem_addr;
                cnt   = rv_delay;
            end
        end
    end

    task automatic walk(
        input  string       tag,
        input  logic [63:0] va,
        input  int          exp_n,
        input  logic        exp_flt,
        output tlb_update_t u
    );
        int   n_evt;
        logic f;
        u     = '0;
        n_evt = -1;
        f     = 1'b0;
        @(negedge clk);
        chk({tag, "_rdy"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_vaddr = va;
        req_asid  = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                req_valid = 1'b0;
                chk({tag, "_busy"}, 64'(req_ready), 64'd0);
                chk({tag, "_addr"}, 64'(mem_addr), 64'(A_L2));
            end
            if (upd.valid || page_fault) begin
                n_evt = n;
                u     = upd;
                f     = page_fault;
                chk({tag, "_wdone"}, 64'(walk_done), 64'd1);
                break;
            end
        end
        chk({tag, "_cyc"}, 64'(n_evt), 64'(exp_n));
        chk({tag, "_flt"}, 64'(f), 64'(exp_flt));
        if (exp_flt) chk({tag, "_fva"}, fault_vaddr, va);
    endtask

    initial begin : wdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        tlb_update_t u;
        int nupd;
        int nflt;
        int nreq;

        rst_ni = 1'b1;
        #1 rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(upd.valid), 64'd0);
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_flt", 64'(page_fault), 64'd0);
        chk("rst_rdy", 64'(req_ready), 64'd1);
        rst_ni = 1'b1;

        pmem[A_L2] = mk(44'h80001, 10'h001);
        pmem[A_L1] = mk(44'h80002, 10'h001);
        pmem[A_L0] = mk(44'h12345, 10'h0C7);

        walk("t4k", VA4K, 7, 1'b0, u);
        chk("t4k_ppn", 64'(u.content.ppn), 64'h12345);
        chk("t4k_2m", 64'(u.is_2M), 64'd0);
        chk("t4k_1g", 64'(u.is_1G), 64'd0);
        chk("t4k_np", 64'(u.napot_bits), 64'd0);
        chk("t4k_vpn", 64'(u.vpn), 64'h40403);
        chk("t4k_asid", 64'(u.asid), 64'd1);
        chk("t4k_pte", 64'(u.content), mk(44'h12345, 10'h0C7));

        pmem[A_L2] = mk(44'h40000, 10'h0C7);
        walk("t1g", VA4K, 3, 1'b0, u);
        chk("t1g_1g", 64'(u.is_1G), 64'd1);
        chk("t1g_2m", 64'(u.is_2M), 64'd0);
        chk("t1g_ppn", 64'(u.content.ppn), 64'h40000);

        pmem[A_L2] = mk(44'h40001, 10'h0C7);
        walk("t1g_mis", VA4K, 3, 1'b1, u);

        pmem[A_L2] = mk(44'h80001, 10'h001);
        pmem[A_L1] = mk(44'h80200, 10'h0C7);
        walk("t2m", VA4K, 5, 1'b0, u);
        chk("t2m_2m", 64'(u.is_2M), 64'd1);
        chk("t2m_ppn", 64'(u.content.ppn), 64'h80200);
        pmem[A_L1] = mk(44'h80002, 10'h001);

        pmem[A_L0NP] = mk(44'h20008, 10'h0C7) | 64'h8000_0000_0000_0000;
`ifdef PTW_SVNAPOT_EN
        walk("tnp", VANP, 7, 1'b0, u);
        chk("tnp_bits", 64'(u.napot_bits), 64'd1);
        chk("tnp_ppn", 64'(u.content.ppn), 64'h20005);
`else
        walk("tnp", VANP, 7, 1'b1, u);
`endif

        pmem[A_L0] = mk(44'h80003, 10'h001);
        walk("tnl", VA4K, 7, 1'b1, u);
        pmem[A_L0] = mk(44'h12345, 10'h087);
        walk("tna", VA4K, 7, 1'b1, u);
        pmem[A_L0] = mk(44'h12345, 10'h0C7);

        pmem[A_L2] = mk(44'h40000, 10'h0C7);
        gnt_stall  = 2;
        rv_delay   = 1;
        walk("tstall", VA4K, 6, 1'b0, u);
        chk("tstall_1g", 64'(u.is_1G), 64'd1);
        rv_delay = 4;

        nupd = 0;
        nflt = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_vaddr = VA4K;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) req_valid = 1'b0;
            if (n == 2) flush_i = 1'b1;
            if (n == 3) flush_i = 1'b0;
            if (upd.valid) nupd++;
            if (page_fault) nflt++;
            if (n == 6) chk("tfl_busy", 64'(req_ready), 64'd0);
            if (n == 7) chk("tfl_rdy", 64'(req_ready), 64'd1);
        end
        chk("tfl_upd", 64'(nupd), 64'd0);
        chk("tfl_flt", 64'(nflt), 64'd0);

        pmem[A_L2] = mk(44'h80001, 10'h001);
        rv_delay   = 3;
        @(negedge clk);
        req_valid = 1'b1;
        req_vaddr = VA4K;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        chk("trst_valid", 64'(upd.valid), 64'd0);
        chk("trst_req", 64'(mem_req), 64'd0);
        chk("trst_addr", 64'(mem_addr), 64'd0);
        chk("trst_flt", 64'(page_fault), 64'd0);
        chk("trst_done", 64'(walk_done), 64'd0);
        chk("trst_fva", fault_vaddr, 64'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        nupd = 0;
        nflt = 0;
        nreq = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (upd.valid) nupd++;
            if (page_fault) nflt++;
            if (mem_req) nreq++;
        end
        chk("trst_lupd", 64'(nupd), 64'd0);
        chk("trst_lflt", 64'(nflt), 64'd0);
        chk("trst_lreq", 64'(nreq), 64'd0);
        rv_delay = 0;

        walk("tpost", VA4K, 7, 1'b0, u);
        chk("tpost_ppn", 64'(u.content.ppn), 64'h12345);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sv39_ptw_napot.md
# sv39_ptw_napot

Sv39 hardware page-table walker that sits directly upstream of the TLB. It accepts a TLB miss, fetches up to three PTEs over a single-outstanding memory port, and validates each one, including Svnapot 64 KiB encodings. It then either emits a one-cycle `tlb_update_t` refill, whose `napot_bits` field the TLB consumes, or reports a page fault. It sits between the MMU miss path and the data-cache PTW port.

## Interface
- `ASID_WIDTH`, default 1: ASID width; must match the TLB.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: SFENCE.VMA; aborts the walk in progress.
- `satp_ppn_i` in 44: root page-table PPN.
- `req_valid_i` / `req_ready_o` in/out 1: miss handshake.
- `req_vaddr_i` in `riscv::VLEN`: missing virtual address.
- `req_asid_i` in `ASID_WIDTH`: ASID of the miss.
- `mem_req_o` / `mem_gnt_i` out/in 1: PTE read request and grant.
- `mem_addr_o` out 56: PTE physical address.
- `mem_rvalid_i` in 1: read data valid.
- `mem_rdata_i` in 64: PTE data.
- `update_o` out `tlb_update_t`: refill to the TLB; `valid` is a one-cycle pulse.
- `walk_done_o` out 1: pulses with every walk end (refill or fault).
- `page_fault_o` out 1: one-cycle pulse.
- `fault_vaddr_o` out `riscv::VLEN`: faulting vaddr, held until the next accepted request.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE, ERR, DRAIN.
- IDLE:
  - `req_ready_o = !flush_i`.
  - On handshake, latch vaddr and ASID, set `lvl=2` and `ptr=satp_ppn_i`, go to REQ.
- REQ:
  - `mem_req_o=1`, `mem_addr_o={ptr, vpn[lvl], 3'b000}`.
  - Hold the request until `mem_gnt_i`, then go to WAIT.
- WAIT: on `mem_rvalid_i`, evaluate the PTE in the same cycle.
  - `V=0`, or `R=0 && W=1`, or reserved bits [62:54] nonzero gives ERR.
  - Non-leaf (`R|X=0`):
    - At `lvl=0`, go to ERR.
    - Otherwise set `ptr=pte.ppn`, `lvl--`, go to REQ.
  - Leaf:
    - `A=0` gives ERR. There is no hardware A/D update.
    - Misaligned superpage gives ERR: at lvl 2, `ppn[17:0]!=0`; at lvl 1, `ppn[8:0]!=0`.
    - Otherwise latch the PTE and go to DONE.
  - Svnapot, for a leaf with N (bit 63):
    - Legal only at `lvl=0` with `ppn[3:0]==4'b1000`. This sets `napot_bits=1`, and `content.ppn[3:0]` is replaced by `vaddr[15:12]`.
    - Any other N usage gives ERR.
- DONE:
  - `update_o.valid=1`, `is_1G=(lvl==2)`, `is_2M=(lvl==1)`.
  - `vpn=vaddr[38:12]`, `asid`, `content` = latched PTE.
  - `walk_done_o=1`, then go to IDLE.
- ERR: `page_fault_o=1`, `walk_done_o=1`, latch `fault_vaddr_o`, then go to IDLE.
- `flush_i` handling:
  - In REQ: keep `mem_req_o` until granted, then go to DRAIN.
  - In WAIT: if `mem_rvalid_i` is absent that cycle, go to DRAIN. If it is present, discard the data and go to IDLE.
  - In DONE or ERR: the output pulse still fires. The TLB prioritises flush.
- DRAIN: wait for `mem_rvalid_i`, discard the data, go to IDLE. No update and no fault.
- Reset values: all outputs 0, FSM=IDLE. `req_ready_o` is 1 after reset.

## Timing
- At most one memory transaction is outstanding.
- Request accepted in cycle 0 with gnt in the REQ cycle and rvalid the next cycle:
  - 1G leaf: update in cycle 3.
  - 2M leaf: update in cycle 5.
  - 4K leaf: update in cycle 7.
- Each gnt or rvalid stall adds one cycle per stall cycle.
- Fault pulse timing equals the update timing at the faulting level.
- `req_ready_o` is 0 from the cycle after acceptance through DONE/ERR/DRAIN.
- Back-to-back walks: the next request can be accepted in the cycle after DONE.

## Configuration
- `PTW_SVNAPOT_EN` defined: N-bit handling as described above.
- `PTW_SVNAPOT_EN` undefined: bit 63 is treated as a reserved bit, so any PTE with N=1 faults. `napot_bits` is tied to 0.

## Structure
- `tlb_update_t` (with the `napot_bits` field) and the level encoding live in `ariane_pkg`.
- `pte_t` with the `n` field lives in `riscv`.
- Sub-module `ptw_pte_check` is combinational. It takes the PTE and level and outputs `{invalid, leaf, misaligned, napot}`.

## Test plan
- satp ppn `0x80000`, three valid levels, leaf at lvl 0 with `ppn=0x12345`, zero stalls -> update in cycle 7 with `content.ppn=0x12345`, `is_2M=0`, `is_1G=0`.
- Leaf at lvl 2 with `ppn=0x40000` -> update in cycle 3 with `is_1G=1`. Repeat with `ppn=0x40001` -> `page_fault_o` in cycle 3.
- `PTW_SVNAPOT_EN` on, lvl 0 leaf N=1 `ppn=0x2_0008`, vaddr[15:12]=5 -> `napot_bits=1`, `ppn=0x2_0005`. Same PTE with the macro off -> fault.
- lvl 0 PTE non-leaf, and `A=0` leaf -> fault each time; `fault_vaddr_o` equals the request vaddr.
- `flush_i` during WAIT with rvalid delayed 4 cycles -> DRAIN, no update, no fault, `req_ready_o=1` the cycle after rvalid.
- Reset asserted mid-WAIT -> all outputs 0 immediately, IDLE; a late rvalid after reset is ignored.
